// File: rtl/lfsr_share_ctrl_pkg.sv
// rtl/lfsr_share_ctrl_pkg.sv - shared types, limits and tap table for lfsr_share_ctrl
package lfsr_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEED  = 2'd2
  } share_state_t;

  // Primitive feedback taps, bit i-1 set for tap i; the MSB tap is always present.
  function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_share_ctrl_core.sv
// rtl/lfsr_share_ctrl_core.sv - zero-inclusive full-period LFSR (de Bruijn sequence)
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [MAX_WIDTH-1:0] TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0]     TAPS      = TAPS_FULL[WIDTH-1:0];

  logic fb;
  logic [WIDTH-1:0] nxt;

  // Inverting feedback when the low bits are all zero splices the all-zero state
  // between 100..0 and 00..01, stretching the period to 2^WIDTH.
  always_comb begin
    fb  = (^(state & TAPS)) ^ (state[WIDTH-2:0] == '0);
    nxt = {state[WIDTH-2:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst)       state <= '0;
    else if (load) state <= load_val;
    else if (en)   state <= nxt;
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// rtl/lfsr_share_ctrl.sv - round-robin sharing of one LFSR word source between requesters
// Optional wait-time checker enabled by LFSR_SHARE_STARVE_CHK_EN (adds starve_err).
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_out,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  output logic               period_wrap,
  output logic               busy
`ifdef LFSR_SHARE_STARVE_CHK_EN
  ,
  output logic               starve_err
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  share_state_t     fsm;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] adv_cnt;
  logic [WIDTH-1:0] lfsr_state;
  logic             found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cidx;
  int               cand;

  lfsr_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (found & ~seed_load),
    .load     (seed_load),
    .load_val (seed),
    .state    (lfsr_state)
  );

  // Search begins just past the last winner so a held request cannot lock others out.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr;
    cand    = 0;
    cidx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      cidx = PW'(cand);
      if (!found && req[cidx]) begin
        found   = 1'b1;
        win_idx = cidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      ptr         <= PW'(NUM_REQ - 1);
      gnt         <= '0;
      rnd_out     <= '0;
      period_wrap <= 1'b0;
      adv_cnt     <= '0;
    end else if (seed_load) begin
      fsm         <= SEED;
      gnt         <= '0;
      rnd_out     <= '0;
      period_wrap <= 1'b0;
      adv_cnt     <= '0;
    end else if (found) begin
      fsm         <= ISSUE;
      gnt         <= NUM_REQ'(1) << win_idx;
      rnd_out     <= lfsr_state;
      ptr         <= win_idx;
      period_wrap <= (adv_cnt == '1);
      adv_cnt     <= adv_cnt + 1'b1;
    end else begin
      fsm         <= IDLE;
      gnt         <= '0;
      rnd_out     <= '0;
      period_wrap <= 1'b0;
    end
  end

  assign busy = (gnt != '0) | (fsm == SEED);

`ifdef LFSR_SHARE_STARVE_CHK_EN
  localparam int CW = $clog2(NUM_REQ) + 1;

  logic [CW-1:0] wait_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (found && !seed_load && win_idx == PW'(i)) wait_cnt[i] <= '0;
        else if (req[i] && wait_cnt[i] != '1)         wait_cnt[i] <= wait_cnt[i] + 1'b1;
        if (wait_cnt[i] > CW'(NUM_REQ)) starve_err <= 1'b1;
      end
    end
  end
`endif

endmodule
